// File: rtl/lsu_stage.sv
// Load/store stage between execute and write-back. One memory transaction
// may be outstanding on the request/ack data bus. Execute is stalled while
// it is in flight, and a bus that never acknowledges is aborted by a timeout.
module lsu_stage #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_we,
    output logic        stall_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic        is_load_q;
    logic [7:0]  tmo_cnt;

    logic        accept, is_mem, legal, misaligned, start_mem;
    logic        ack_hit, timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane, load_data;

    assign stall_o = (state == BUSY);
    assign accept  = ex_valid && (state == IDLE);
    assign is_mem  = ex_is_load || ex_is_store;
    assign ack_hit = (state == BUSY) && bus_ack;
    assign timeout = (state == BUSY) && !bus_ack && (tmo_cnt == 8'(BUS_TIMEOUT - 1));
    assign start_mem = accept && is_mem && legal && !misaligned;

    // Classify the offered memory op and build its byte enables and lane-replicated store data
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (ex_is_load) begin
            legal = (ex_funct3 == 3'd0) || (ex_funct3 == 3'd1) || (ex_funct3 == 3'd2) ||
                    (ex_funct3 == 3'd4) || (ex_funct3 == 3'd5);
        end else begin
            legal = (ex_funct3 == 3'd0) || (ex_funct3 == 3'd1) || (ex_funct3 == 3'd2);
            case (ex_funct3[1:0])
                2'd0: begin
                    be_next    = 4'b0001 << ex_addr[1:0];
                    wdata_next = {4{ex_sdata[7:0]}};
                end
                2'd1: begin
                    be_next    = ex_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{ex_sdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = ex_sdata;
                end
            endcase
        end
        if (ex_funct3[1:0] == 2'd1)
            misaligned = ex_addr[0];
        else if (ex_funct3[1:0] == 2'd2)
            misaligned = |ex_addr[1:0];
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        lane      = bus_rdata >> {addr_lo_q, 3'b000};
        load_data = bus_rdata;
        case (funct3_q)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'h0, lane[7:0]};
            3'd5:    load_data = {16'h0, lane[15:0]};
            default: load_data = bus_rdata;
        endcase
    end

    // Next state: enter BUSY on an aligned legal memory op, leave on ack or timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mem) state_next = BUSY;
            BUSY:    if (ack_hit || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset discards any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Bus request registers, latched op context, timeout counter and write-back results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'h0;
            wb_we     <= 1'b0;
            wb_waddr  <= 5'h0;
            wb_wdata  <= 32'h0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            funct3_q  <= 3'h0;
            addr_lo_q <= 2'h0;
            waddr_q   <= 5'h0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            tmo_cnt   <= 8'h0;
        end else begin
            wb_we    <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_we    <= ex_we && (ex_waddr != 5'd0);
                    wb_waddr <= ex_waddr;
                    wb_wdata <= ex_wdata;
                end else if (legal && misaligned) begin
                    misalign <= 1'b1;
                end else if (legal) begin
                    funct3_q  <= ex_funct3;
                    addr_lo_q <= ex_addr[1:0];
                    waddr_q   <= ex_waddr;
                    we_q      <= ex_we;
                    is_load_q <= ex_is_load;
                    tmo_cnt   <= 8'h0;
                    bus_req   <= 1'b1;
                    bus_we    <= !ex_is_load;
                    bus_addr  <= {ex_addr[31:2], 2'b00};
                    bus_be    <= ex_is_load ? 4'b1111 : be_next;
                    bus_wdata <= ex_is_load ? 32'h0 : wdata_next;
                end
            end else if (state == BUSY) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    if (is_load_q) begin
                        wb_we    <= we_q && (waddr_q != 5'd0);
                        wb_waddr <= waddr_q;
                        wb_wdata <= load_data;
                    end
                end else if (timeout) begin
                    bus_req <= 1'b0;
                    bus_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with hand-computed expectations, timeout of 4.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'h0;
    logic [31:0] ex_addr = 32'h0, ex_sdata = 32'h0, ex_wdata = 32'h0;
    logic [4:0]  ex_waddr = 5'h0;
    logic        ex_we = 1'b0;
    logic        stall_o, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        misalign, bus_err;

    int checks = 0;
    int failures = 0;
    int stallCnt;

    lsu_stage #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_we(ex_we),
        .stall_o(stall_o), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] wdata, input logic [4:0] waddr, input logic we);
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_sdata = sdata; ex_wdata = wdata; ex_waddr = waddr; ex_we = we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_req", 32'(bus_req), 32'd0);
        checkOutput("rst_wbwe", 32'(wb_we), 32'd0);
        checkOutput("rst_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        tick();

        // ADD result to x5
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
        tick();
        idle();
        checkOutput("add_we", 32'(wb_we), 32'd1);
        checkOutput("add_waddr", 32'(wb_waddr), 32'd5);
        checkOutput("add_wdata", wb_wdata, 32'h0000_1234);
        checkOutput("add_stall", 32'(stall_o), 32'd0);
        tick();
        checkOutput("add_pulse", 32'(wb_we), 32'd0);

        // write to x0 is suppressed
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1);
        tick();
        idle();
        checkOutput("x0_we", 32'(wb_we), 32'd0);

        // illegal store width: nothing happens
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 32'h100, 32'h1, 32'h0, 5'd1, 1'b0);
        tick();
        idle();
        checkOutput("ill_req", 32'(bus_req), 32'd0);
        checkOutput("ill_mis", 32'(misalign), 32'd0);
        checkOutput("ill_we", 32'(wb_we), 32'd0);

        // LB from 0x1003, ack on the first BUSY cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        idle();
        checkOutput("lb_req", 32'(bus_req), 32'd1);
        checkOutput("lb_stall", 32'(stall_o), 32'd1);
        checkOutput("lb_addr", bus_addr, 32'h1000);
        checkOutput("lb_be", 32'(bus_be), 32'hF);
        checkOutput("lb_buswe", 32'(bus_we), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h80AB_CDEF;
        tick();
        bus_ack = 1'b0;
        checkOutput("lb_we", 32'(wb_we), 32'd1);
        checkOutput("lb_waddr", 32'(wb_waddr), 32'd7);
        checkOutput("lb_wdata", wb_wdata, 32'hFFFF_FF80);
        checkOutput("lb_reqdrop", 32'(bus_req), 32'd0);
        checkOutput("lb_unstall", 32'(stall_o), 32'd0);

        // LHU from 0x2002, ack on 4th BUSY cycle (coincides with timeout), ADD held behind it
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0055, 5'd3, 1'b1);
        stallCnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall_o) stallCnt++;
            tick();
        end
        bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
        if (stall_o) stallCnt++;
        tick();
        bus_ack = 1'b0;
        checkOutput("lhu_stallcnt", 32'(stallCnt), 32'd4);
        checkOutput("lhu_we", 32'(wb_we), 32'd1);
        checkOutput("lhu_waddr", 32'(wb_waddr), 32'd9);
        checkOutput("lhu_wdata", wb_wdata, 32'h0000_BEEF);
        checkOutput("lhu_noerr", 32'(bus_err), 32'd0);
        checkOutput("lhu_unstall", 32'(stall_o), 32'd0);
        tick();
        idle();
        checkOutput("b2b_we", 32'(wb_we), 32'd1);
        checkOutput("b2b_waddr", 32'(wb_waddr), 32'd3);
        checkOutput("b2b_wdata", wb_wdata, 32'h0000_0055);
        tick();

        // SH to 0x3002
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 32'h3002, 32'h1234_5678, 32'h0, 5'd4, 1'b1);
        tick();
        idle();
        checkOutput("sh_be", 32'(bus_be), 32'hC);
        checkOutput("sh_wdata", bus_wdata, 32'h5678_5678);
        checkOutput("sh_buswe", 32'(bus_we), 32'd1);
        checkOutput("sh_addr", bus_addr, 32'h3000);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        checkOutput("sh_wbwe", 32'(wb_we), 32'd0);
        checkOutput("sh_reqdrop", 32'(bus_req), 32'd0);

        // SB to 0x3001 lane
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h3001, 32'h0000_00A5, 32'h0, 5'd4, 1'b0);
        tick();
        idle();
        checkOutput("sb_be", 32'(bus_be), 32'h2);
        checkOutput("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;

        // misaligned LW
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'h4001, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        idle();
        checkOutput("mis_req", 32'(bus_req), 32'd0);
        checkOutput("mis_pulse", 32'(misalign), 32'd1);
        checkOutput("mis_we", 32'(wb_we), 32'd0);
        checkOutput("mis_stall", 32'(stall_o), 32'd0);
        tick();
        checkOutput("mis_clear", 32'(misalign), 32'd0);

        // SW with no ack: aborts after 4 BUSY cycles
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 32'h5000, 32'hCAFE_0001, 32'h0, 5'd0, 1'b0);
        tick();
        idle();
        checkOutput("sw_be", 32'(bus_be), 32'hF);
        checkOutput("sw_wdata", bus_wdata, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) begin
            checkOutput("sw_busy_req", 32'(bus_req), 32'd1);
            checkOutput("sw_busy_noerr", 32'(bus_err), 32'd0);
            tick();
        end
        checkOutput("tmo_err", 32'(bus_err), 32'd1);
        checkOutput("tmo_req", 32'(bus_req), 32'd0);
        checkOutput("tmo_stall", 32'(stall_o), 32'd0);
        checkOutput("tmo_we", 32'(wb_we), 32'd0);
        tick();
        checkOutput("tmo_pulse", 32'(bus_err), 32'd0);

        // async reset while BUSY
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'h6000, 32'h0, 32'h0, 5'd8, 1'b1);
        tick();
        idle();
        checkOutput("ar_req_before", 32'(bus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_req", 32'(bus_req), 32'd0);
        checkOutput("ar_stall", 32'(stall_o), 32'd0);
        checkOutput("ar_we", 32'(wb_we), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("ar_noerr", 32'(bus_err), 32'd0);

        // LW after reset
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'h6004, 32'h0, 32'h0, 5'd10, 1'b1);
        tick();
        idle();
        checkOutput("lw_addr", bus_addr, 32'h6004);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0;
        checkOutput("lw_we", 32'(wb_we), 32'd1);
        checkOutput("lw_waddr", 32'(wb_waddr), 32'd10);
        checkOutput("lw_wdata", wb_wdata, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
